// File: rtl/spike_winner_decoder_pkg.sv
// Shared types and defaults for the output-side spike decoder.
//   state_e       : decoder FSM states
//   DEF_*         : default parameter values
//   idx_width()   : width of a neuron index for N neurons
package spike_winner_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SCAN,
        HOLDS
    } state_e;

    localparam int unsigned DEF_N      = 8;
    localparam int unsigned DEF_CW     = 8;
    localparam int unsigned DEF_TU_MAX = 500;
    localparam int unsigned DEF_HOLD   = 50000;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spike_winner_decoder_if.sv
// Handshake/result bundle between the SNN core side and the winner decoder.
//   master : img_start, tu_incre, ops out; busy, win_valid, win_idx, win_count,
//            tie, led_class in (core / host side)
//   slave  : the decoder itself
interface spike_winner_decoder_if
    import spike_winner_decoder_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) ();
    localparam int unsigned IW = idx_width(N);

    logic          img_start;
    logic          tu_incre;
    logic [N-1:0]  ops;
    logic          busy;
    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] win_count;
    logic          tie;
    logic [N-1:0]  led_class;

    modport master (
        output img_start, tu_incre, ops,
        input  busy, win_valid, win_idx, win_count, tie, led_class
    );

    modport slave (
        input  img_start, tu_incre, ops,
        output busy, win_valid, win_idx, win_count, tie, led_class
    );
endinterface

// File: rtl/spike_winner_decoder_counter_bank.sv
// N independent saturating spike counters.
//   clk, rst  : clock, asynchronous active-low reset
//   clr_i     : synchronous clear of every counter (wins over en_i)
//   en_i      : count enable for this cycle
//   inc_i     : per-neuron increment request
//   counts_o  : flat counter values, neuron i at [i*CW +: CW]
module spike_winner_decoder_counter_bank
    import spike_winner_decoder_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [N-1:0]    inc_i,
    output logic [N*CW-1:0] counts_o
);
    logic [N-1:0][CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                // Hold at all-ones instead of wrapping.
                if (inc_i[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign counts_o = cnt_q;

endmodule

// File: rtl/spike_winner_decoder.sv
// Output-side decoder: counts spikes per output neuron over TU_MAX time units,
// then scans the counters one per cycle to find the winner, strobes the result
// and holds a one-hot LED pattern for HOLD cycles.
//   clk, rst  : clock, asynchronous active-low reset
//   bus.slave : img_start, tu_incre, ops in;
//               busy, win_valid, win_idx, win_count, tie, led_class out
module spike_winner_decoder
    import spike_winner_decoder_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned CW     = DEF_CW,
    parameter int unsigned TU_MAX = DEF_TU_MAX,
    parameter int unsigned HOLD   = DEF_HOLD
) (
    input logic                   clk,
    input logic                   rst,
    spike_winner_decoder_if.slave bus
);
    localparam int unsigned IW = idx_width(N);

    state_e               state_q, state_d;
    logic [15:0]          tu_cnt_q;
    logic [23:0]          hold_cnt_q;
    logic [IW-1:0]        scan_i_q;
    logic [CW-1:0]        best_q;
    logic [IW-1:0]        bidx_q;
    logic                 btie_q;

    logic                 win_valid_q;
    logic [IW-1:0]        win_idx_q;
    logic [CW-1:0]        win_count_q;
    logic                 tie_q;
    logic [N-1:0]         led_q;

    logic [N*CW-1:0]      counts_flat;
    logic [N-1:0][CW-1:0] counts;
    logic [CW-1:0]        cur;
    logic [CW-1:0]        cand_best;
    logic [IW-1:0]        cand_idx;
    logic                 cand_tie;

    logic                 tu_last, scan_last, hold_last;
    logic                 busy_d, acc_en;

    spike_winner_decoder_counter_bank #(
        .N  (N),
        .CW (CW)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (bus.img_start),
        .en_i     (acc_en),
        .inc_i    (bus.ops),
        .counts_o (counts_flat)
    );

    assign counts    = counts_flat;
    assign cur       = counts[scan_i_q];
    assign tu_last   = bus.tu_incre && (tu_cnt_q == 16'(TU_MAX - 1));
    assign scan_last = (scan_i_q == IW'(N - 1));
    assign hold_last = (hold_cnt_q == 24'(HOLD - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; img_start restarts from any state.
    always_comb begin
        state_d = state_q;
        if (bus.img_start) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ACCUM:   if (tu_last)   state_d = SCAN;
                SCAN:    if (scan_last) state_d = HOLDS;
                HOLDS:   if (hold_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy_d = 1'b0;
        acc_en = 1'b0;
        case (state_q)
            ACCUM: begin
                busy_d = 1'b1;
                acc_en = bus.tu_incre;
            end
            SCAN:    busy_d = 1'b1;
            default: ;
        endcase
    end

    // One argmax step: the value the running best/idx/tie takes after this
    // neuron. Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        cand_best = best_q;
        cand_idx  = bidx_q;
        cand_tie  = btie_q;
        if (scan_i_q == '0) begin
            cand_best = cur;
            cand_idx  = '0;
            cand_tie  = 1'b0;
        end else if (cur > best_q) begin
            cand_best = cur;
            cand_idx  = scan_i_q;
            cand_tie  = 1'b0;
        end else if (cur == best_q) begin
            cand_tie  = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tu_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            scan_i_q    <= '0;
            best_q      <= '0;
            bidx_q      <= '0;
            btie_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
            win_count_q <= '0;
            tie_q       <= 1'b0;
            led_q       <= '0;
        end else begin
            win_valid_q <= 1'b0;
            if (bus.img_start) begin
                // Result registers are deliberately left alone here.
                tu_cnt_q <= '0;
                led_q    <= '0;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (bus.tu_incre) begin
                            tu_cnt_q <= tu_cnt_q + 16'd1;
                            scan_i_q <= '0;
                        end
                    end
                    SCAN: begin
                        best_q   <= cand_best;
                        bidx_q   <= cand_idx;
                        btie_q   <= cand_tie;
                        scan_i_q <= scan_i_q + IW'(1);
                        if (scan_last) begin
                            win_valid_q <= 1'b1;
                            win_idx_q   <= cand_idx;
                            win_count_q <= cand_best;
                            tie_q       <= cand_tie;
                            led_q       <= N'(1) << cand_idx;
                            hold_cnt_q  <= '0;
                        end
                    end
                    HOLDS: begin
                        hold_cnt_q <= hold_cnt_q + 24'd1;
                        if (hold_last) begin
                            led_q <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy      = busy_d;
    assign bus.win_valid = win_valid_q;
    assign bus.win_idx   = win_idx_q;
    assign bus.win_count = win_count_q;
    assign bus.tie       = tie_q;
    assign bus.led_class = led_q;

endmodule
